// File: rtl/tlc_ctrl.sv
// Traffic-light controller: RED -> GREEN -> YELLOW -> RED, each light held for a
// programmed number of seconds; durations are written over a valid/ready port while idle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | lights off, accepting duration writes, waiting for a valid start
// RED    | red lamp on for red_q seconds
// GREEN  | green lamp on for grn_q seconds
// YELLOW | yellow lamp on for yel_q seconds
module tlc_ctrl #(
    parameter real FREQ        = 0.001,
    parameter int  ADDR_WIDTH  = 3,
    parameter int  ADDR_RED    = 0,
    parameter int  ADDR_YELLOW = 1,
    parameter int  ADDR_GREEN  = 2,
    parameter int  DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic [1:0]            state
);

    localparam int CPS = $rtoi(FREQ * 1000000.0 + 0.5);
    localparam int PW  = (CPS > 1) ? $clog2(CPS) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CPS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RED    = 2'd1,
        S_YELLOW = 2'd2,
        S_GREEN  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] red_q, red_d;
    logic [DATA_WIDTH-1:0] yel_q, yel_d;
    logic [DATA_WIDTH-1:0] grn_q, grn_d;
    logic [DATA_WIDTH-1:0] sec_q, sec_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] cur_dur;
    logic                  wr_en;
    logic                  tick;
    logic                  all_set;

    assign ready   = (state_q == S_IDLE);
    assign state   = state_q;
    assign wr_en   = valid && ready;
    assign tick    = (pre_q == PRE_TC);
    assign all_set = (red_d != '0) && (yel_d != '0) && (grn_d != '0);

    always_comb begin
        cur_dur = red_q;
        case (state_q)
            S_GREEN:  cur_dur = grn_q;
            S_YELLOW: cur_dur = yel_q;
            default:  cur_dur = red_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        red_d   = red_q;
        yel_d   = yel_q;
        grn_d   = grn_q;
        sec_d   = sec_q;
        pre_d   = pre_q;
        start_d = 1'b0;

        if (wr_en) begin
            if (addr == ADDR_WIDTH'(ADDR_RED))    red_d = data;
            if (addr == ADDR_WIDTH'(ADDR_YELLOW)) yel_d = data;
            if (addr == ADDR_WIDTH'(ADDR_GREEN))  grn_d = data;
        end

        case (state_q)
            S_IDLE: begin
                pre_d   = '0;
                sec_d   = '0;
                // A green write arms start; the FSM enters RED on the following edge.
                start_d = wr_en && (addr == ADDR_WIDTH'(ADDR_GREEN)) && all_set;
                if (start_q && all_set) begin
                    state_d = S_RED;
                end
            end
            default: begin
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (tick) begin
                    if (sec_q == cur_dur - DATA_WIDTH'(1)) begin
                        sec_d = '0;
                        case (state_q)
                            S_RED:   state_d = S_GREEN;
                            S_GREEN: state_d = S_YELLOW;
                            default: state_d = S_RED;
                        endcase
                    end else begin
                        sec_d = sec_q + DATA_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            red_q   <= '0;
            yel_q   <= '0;
            grn_q   <= '0;
            sec_q   <= '0;
            pre_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            red_q   <= red_d;
            yel_q   <= yel_d;
            grn_q   <= grn_d;
            sec_q   <= sec_d;
            pre_q   <= pre_d;
            start_q <= start_d;
        end
    end

endmodule

// File: tb/tb_tlc_ctrl.sv
// Directed bench for tlc_ctrl at the default 1000 cycles-per-second timebase:
// start latency, per-light hold lengths, locked registers, async reset, zero-duration start.
module tb_tlc_ctrl;

    localparam int CPS = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] data = '0;
    logic       valid = 1'b0;
    logic       ready;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tlc_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .state (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Called at a negedge; leaves valid low at the next negedge (one posedge in between).
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr  = a;
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic program_lights(input logic [7:0] r, input logic [7:0] y, input logic [7:0] g);
        wr(3'd0, r);
        wr(3'd1, y);
        wr(3'd2, g);
    endtask

    // Counts samples while state stays at s (bounded), checks count and ready level.
    task automatic hold(input string tag, input logic [1:0] s, input int exp_cycles);
        int n   = 0;
        int bad = 0;
        while (state === s && n < exp_cycles + 20) begin
            if (ready !== (s == 2'd0)) bad++;
            n++;
            @(negedge clk);
        end
        check_eq(tag, n, exp_cycles);
        check_eq({tag, "_ready"}, bad, 0);
    endtask

    task automatic idle_hold(input string tag, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (state !== 2'd0 || ready !== 1'b1) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    task automatic check_start(input string tag);
        check_eq({tag, "_lat_idle"}, state, 2'd0);
        @(negedge clk);
        check_eq({tag, "_red"}, state, 2'd1);
        check_eq({tag, "_ready0"}, ready, 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_state", state, 2'd0);
        check_eq("rst_ready", ready, 1'b1);
        rst = 1'b1;
        idle_hold("reset_idle", 2000);

        program_lights(8'd3, 8'd1, 8'd5);
        check_start("run1");
        hold("run1_red", 2'd1, 3 * CPS);
        hold("run1_green", 2'd3, 5 * CPS);
        hold("run1_yellow", 2'd2, 1 * CPS);
        hold("run1_red2", 2'd1, 3 * CPS);
        check_eq("run1_green_again", state, 2'd3);

        wr(3'd0, 8'd1);
        hold("locked_green", 2'd3, 5 * CPS - 1);
        hold("locked_yellow", 2'd2, 1 * CPS);
        hold("locked_red", 2'd1, 3 * CPS);

        repeat (100) @(negedge clk);
        check_eq("mid_green", state, 2'd3);
        #2 rst = 1'b0;
        #1;
        check_eq("async_state", state, 2'd0);
        check_eq("async_ready", ready, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle_hold("post_reset_idle", 2000);

        program_lights(8'd4, 8'd2, 8'd7);
        check_start("run2");
        hold("run2_red", 2'd1, 4 * CPS);
        hold("run2_green", 2'd3, 7 * CPS);
        hold("run2_yellow", 2'd2, 2 * CPS);
        hold("run2_red2", 2'd1, 4 * CPS);

        pulse_reset();
        wr(3'd1, 8'd1);
        wr(3'd2, 8'd1);
        repeat (3) @(negedge clk);
        check_eq("zero_red_state", state, 2'd0);
        check_eq("zero_red_ready", ready, 1'b1);

        wr(3'd5, 8'd9);
        wr(3'd2, 8'd1);
        repeat (3) @(negedge clk);
        check_eq("addr5_ignored", state, 2'd0);

        wr(3'd0, 8'd2);
        wr(3'd2, 8'd0);
        repeat (3) @(negedge clk);
        check_eq("zero_green_state", state, 2'd0);
        check_eq("zero_green_ready", ready, 1'b1);

        wr(3'd2, 8'd2);
        check_start("retry");
        hold("retry_red", 2'd1, 2 * CPS);
        hold("retry_green", 2'd3, 2 * CPS);
        hold("retry_yellow", 2'd2, 1 * CPS);
        check_eq("retry_wrap", state, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlc_ctrl.md
# tlc_ctrl

Programmable traffic-light controller that cycles RED → GREEN → YELLOW → RED, holding each light for a software-programmed number of seconds. Three 8-bit duration registers are written over a simple valid/ready register port. A prescaler derived from the clock frequency parameter converts clock cycles to seconds. The block sits at the intersection-control level and drives a 2-bit light-state code to the lamp drivers.

## Interface
- FREQ, 0.001: input clock frequency in MHz (real). Cycles per second CPS = round(FREQ × 1 000 000); the default gives CPS = 1000.
- ADDR_WIDTH, 3: width of the register address bus.
- ADDR_RED, 0: address of the red-duration register.
- ADDR_YELLOW, 1: address of the yellow-duration register.
- ADDR_GREEN, 2: address of the green-duration register.
- DATA_WIDTH, 8: width of the data bus and of the duration registers, in seconds (minimum 8).
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  ADDR_WIDTH  register address.
- data  in  DATA_WIDTH  duration value in seconds.
- valid  in  1  write request.
- ready  out  1  configuration port accepting writes.
- state  out  2  light code: 0 = IDLE (all off), 1 = RED, 2 = YELLOW, 3 = GREEN.

## Operation
- Reset (rst low, asynchronous):
  - The red, yellow and green registers clear to 0.
  - The prescaler and seconds counter clear to 0.
  - state = 0 (IDLE) and ready = 1.
- Write handling:
  - A write is accepted on a rising edge when valid && ready.
  - addr equal to ADDR_RED, ADDR_YELLOW or ADDR_GREEN loads data into the matching register.
  - Any other address is ignored.
  - Writes are accepted only in IDLE.
- Start condition:
  - Start occurs when a write to ADDR_GREEN is accepted in IDLE and, after that edge, all three registers are nonzero.
  - On start, the FSM enters RED and ready drops to 0.
  - If any register is 0, the FSM stays in IDLE with ready = 1. The host may rewrite and retry.
- FSM: IDLE → RED → GREEN → YELLOW → RED …, repeating indefinitely.
  - The only way back to IDLE is reset.
  - Registers are locked while running.
- Timebase:
  - The prescaler counts 0..CPS−1 and wraps; a second-tick is asserted on the terminal count.
  - A seconds counter increments on each tick.
  - On the tick where seconds == duration−1 of the current light, the FSM advances and both counters clear.
- Each light is therefore held exactly duration × CPS cycles. A full period is (Tred + Tgreen + Tyellow) × CPS cycles.
- Width rules:
  - The prescaler is wide enough for CPS−1; the seconds counter is DATA_WIDTH bits.
  - The maximum duration is 2^DATA_WIDTH − 1 s, with no wrap inside a light.
- ready = 1 iff state == IDLE.

## Timing
- The write for ADDR_GREEN is accepted at edge N. state becomes 1 (RED) after edge N+1, and ready goes to 0 after edge N+1.
- The counters start from 0 at the edge that enters RED. RED lasts Tred × CPS cycles from that edge.
- Each transition is registered: state changes exactly at the edge where the terminal count is reached.
- Reset mid-operation: outputs go to state = 0 and ready = 1 immediately (asynchronous), and all configuration is lost.
- After rst deasserts, the block needs a full reprogramming before it runs again.
- valid with ready = 0 has no effect on the registers or the FSM.

## Test plan
- Reset check: hold rst low for 4 cycles, then release with valid = 0. Required: state = 0, ready = 1, and no transitions occur for 100000 cycles.
- Basic program (FREQ = 0.001): release rst, then write red = 3, yellow = 1, green = 5 on three consecutive cycles. Required:
  - RED for 3000 cycles, then GREEN for 5000, then YELLOW for 1000.
  - The 9000-cycle period repeats across 100000 cycles.
  - ready stays 0 throughout.
- Reset mid-run: assert rst during GREEN. Required: state = 0 and ready = 1 immediately. After release, state remains 0 for 100000 cycles with no writes.
- Reprogram: after reset, write red = 4, yellow = 2, green = 7. Required: RED 4000, GREEN 7000, YELLOW 2000 cycles (period 13000).
- Locked registers and zero duration:
  - Writes while running (e.g. red = 1) leave the timing unchanged.
  - Programming green = 0 leaves state = 0 and ready = 1.
  - A write to address 5 is ignored.
